// File: rtl/ejtag_pkg.sv
// Shared EJTAG definitions: TAP state codes, instruction codes and DR select codes.
// Used by the TAP/IR controller and by all data-register logic.
package ejtag_pkg;

  localparam int unsigned TAP_W  = 4;
  localparam int unsigned INSN_W = 5;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [TAP_W-1:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  localparam logic [INSN_W-1:0] INSN_IDCODE  = 5'h01;
  localparam logic [INSN_W-1:0] INSN_IMPCODE = 5'h03;
  localparam logic [INSN_W-1:0] INSN_ADDRESS = 5'h08;
  localparam logic [INSN_W-1:0] INSN_DATA    = 5'h09;
  localparam logic [INSN_W-1:0] INSN_TCB_A   = 5'h10;
  localparam logic [INSN_W-1:0] INSN_TCB_B   = 5'h12;
  localparam logic [INSN_W-1:0] INSN_EXTEST  = 5'h00;
  localparam logic [INSN_W-1:0] INSN_BYPASS  = 5'h02;

  localparam logic [SEL_W-1:0] SEL_IDCODE  = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_IMPCODE = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_ADDRESS = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_DATA    = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_TCB_A   = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_TCB_B   = 4'b0101;
  localparam logic [SEL_W-1:0] SEL_EXTEST  = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_BYPASS  = 4'b0111;

endpackage

// File: rtl/ejtag_ir_decode.sv
// Combinational instruction -> data-register select decode.
// Codes are compared zero-extended, so any non-zero bit above the 5-bit code space yields BYPASS.
module ejtag_ir_decode
  import ejtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 5
) (
  input  logic [IR_WIDTH-1:0] i_ir,
  output logic [SEL_W-1:0]    o_sel_c
);

  localparam int unsigned CMP_W = (IR_WIDTH > INSN_W) ? IR_WIDTH : INSN_W;

  logic [CMP_W-1:0] w_code;

  always_comb begin
    w_code  = CMP_W'(i_ir);
    o_sel_c = SEL_BYPASS;
    case (w_code)
      CMP_W'(INSN_IDCODE):  o_sel_c = SEL_IDCODE;
      CMP_W'(INSN_IMPCODE): o_sel_c = SEL_IMPCODE;
      CMP_W'(INSN_ADDRESS): o_sel_c = SEL_ADDRESS;
      CMP_W'(INSN_DATA):    o_sel_c = SEL_DATA;
      CMP_W'(INSN_TCB_A):   o_sel_c = SEL_TCB_A;
      CMP_W'(INSN_TCB_B):   o_sel_c = SEL_TCB_B;
      CMP_W'(INSN_EXTEST):  o_sel_c = SEL_EXTEST;
      default:              o_sel_c = SEL_BYPASS;
    endcase
  end

endmodule

// File: rtl/tap_ir_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register and registered DR select.
// ir/sel only change on Update-IR or in Test-Logic-Reset, so a partial shift is never visible.
module tap_ir_ctrl
  import ejtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH       = 5,
  parameter logic [IR_WIDTH-1:0]  IR_RESET_VAL   = IR_WIDTH'(INSN_IDCODE),
  parameter logic [IR_WIDTH-1:0]  IR_CAPTURE_VAL = IR_WIDTH'(2'b01)
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic [TAP_W-1:0]    tap_state,
  output logic [IR_WIDTH-1:0] ir,
  output logic [SEL_W-1:0]    sel,
  output logic                ir_tdo,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                tlr
);

  tap_state_e          r_state;
  tap_state_e          w_state_nxt;
  logic [IR_WIDTH-1:0] r_shift;
  logic [IR_WIDTH-1:0] r_ir;
  logic [SEL_W-1:0]    r_sel;
  logic                r_capture_dr;
  logic                r_shift_dr;
  logic                r_update_dr;
  logic                r_tlr;
  logic [IR_WIDTH-1:0] w_shift_nxt;
  logic [IR_WIDTH-1:0] w_ir_nxt;
  logic                w_ir_load;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [SEL_W-1:0]    w_sel_rst;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) r_state <= TAP_TLR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TAP_TLR:     w_state_nxt = tms ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     w_state_nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   w_state_nxt = tms ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   w_state_nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    w_state_nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   w_state_nxt = tms ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: w_state_nxt = tms ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   w_state_nxt = tms ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   w_state_nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   w_state_nxt = tms ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   w_state_nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    w_state_nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   w_state_nxt = tms ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: w_state_nxt = tms ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   w_state_nxt = tms ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   w_state_nxt = tms ? TAP_SELDR   : TAP_RTI;
      default:     w_state_nxt = TAP_TLR;
    endcase
  end

  // Shift stage and active-instruction next values
  always_comb begin
    w_shift_nxt = r_shift;
    w_ir_nxt    = r_ir;
    w_ir_load   = 1'b0;
    case (r_state)
      TAP_CAPIR: w_shift_nxt = IR_CAPTURE_VAL;
      TAP_SHIR:  w_shift_nxt = {tdi, r_shift[IR_WIDTH-1:1]};
      TAP_UPDIR: begin
        w_ir_nxt  = r_shift;
        w_ir_load = 1'b1;
      end
      TAP_TLR: begin
        w_ir_nxt  = IR_RESET_VAL;
        w_ir_load = 1'b1;
      end
      default: ;
    endcase
  end

  ejtag_ir_decode #(.IR_WIDTH(IR_WIDTH)) u_dec_nxt (
    .i_ir    (w_ir_nxt),
    .o_sel_c (w_sel_nxt)
  );

  ejtag_ir_decode #(.IR_WIDTH(IR_WIDTH)) u_dec_rst (
    .i_ir    (IR_RESET_VAL),
    .o_sel_c (w_sel_rst)
  );

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_shift <= IR_CAPTURE_VAL;
      r_ir    <= IR_RESET_VAL;
      r_sel   <= w_sel_rst;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_ir_load) begin
        r_ir  <= w_ir_nxt;
        r_sel <= w_sel_nxt;
      end
    end
  end

  // Strobes are flops tracking the state register, so they are glitch-free
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_capture_dr <= 1'b0;
      r_shift_dr   <= 1'b0;
      r_update_dr  <= 1'b0;
      r_tlr        <= 1'b1;
    end else begin
      r_capture_dr <= (w_state_nxt == TAP_CAPDR);
      r_shift_dr   <= (w_state_nxt == TAP_SHDR);
      r_update_dr  <= (w_state_nxt == TAP_UPDDR);
      r_tlr        <= (w_state_nxt == TAP_TLR);
    end
  end

  assign tap_state  = r_state;
  assign ir         = r_ir;
  assign sel        = r_sel;
  assign ir_tdo     = r_shift[0];
  assign capture_dr = r_capture_dr;
  assign shift_dr   = r_shift_dr;
  assign update_dr  = r_update_dr;
  assign tlr        = r_tlr;

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// Bench for tap_ir_ctrl: directed scenarios plus a random tms/tdi walk,
// all checked against a table-driven reference model of the TAP and IR.
module tb_tap_ir_ctrl;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       tms;
  logic       tdi;
  logic [3:0] tap_state;
  logic [4:0] ir;
  logic [3:0] sel;
  logic       ir_tdo;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       tlr;

  int n_chk  = 0;
  int n_pass = 0;

  tap_ir_ctrl dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .tdi        (tdi),
    .tap_state  (tap_state),
    .ir         (ir),
    .sel        (sel),
    .ir_tdo     (ir_tdo),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tlr        (tlr)
  );

  always #5 tck = ~tck;

  // Reference model: transition tables indexed by state code, decode by lookup list
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [4:0] insn_tab [8];
  logic [3:0] m_state;
  logic [4:0] m_ir;
  logic [4:0] m_shift;
  logic [3:0] m_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] ref_sel(input logic [4:0] v);
    for (int i = 0; i < 8; i++)
      if (insn_tab[i] == v) return 4'(i);
    return 4'd7;
  endfunction

  task automatic model_reset();
    m_state = 4'hF;
    m_ir    = 5'h01;
    m_sel   = ref_sel(5'h01);
    m_shift = 5'h01;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(tap_state), 32'(m_state));
    chk({tag, ".ir"},    32'(ir),        32'(m_ir));
    chk({tag, ".sel"},   32'(sel),       32'(m_sel));
    chk({tag, ".tdo"},   32'(ir_tdo),    32'(m_shift[0]));
    chk({tag, ".cdr"},   32'(capture_dr), 32'(m_state == 4'h6));
    chk({tag, ".sdr"},   32'(shift_dr),   32'(m_state == 4'h2));
    chk({tag, ".udr"},   32'(update_dr),  32'(m_state == 4'h5));
    chk({tag, ".tlr"},   32'(tlr),        32'(m_state == 4'hF));
  endtask

  // Drive one tck cycle; called just after a falling edge
  task automatic step(input logic t, input logic d);
    logic [3:0] s;
    tms = t;
    tdi = d;
    @(posedge tck);
    s = m_state;
    if (s == 4'hE) m_shift = 5'h01;
    else if (s == 4'hA) m_shift = {d, m_shift[4:1]};
    else if (s == 4'hD) begin m_ir = m_shift; m_sel = ref_sel(m_shift); end
    else if (s == 4'hF) begin m_ir = 5'h01; m_sel = ref_sel(5'h01); end
    m_state = t ? nx1[s] : nx0[s];
    @(negedge tck);
    check_all("step");
  endtask

  // Asynchronous reset pulse that completes between two rising edges
  task automatic reset_pulse();
    trst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst");
    chk("rst.state_f", 32'(tap_state), 32'h0F);
    chk("rst.ir_01",   32'(ir),        32'h01);
    chk("rst.sel_0",   32'(sel),       32'h0);
    chk("rst.tlr_1",   32'(tlr),       32'h1);
    #1 trst_n = 1'b1;
  endtask

  task automatic goto_tlr();
    repeat (5) step(1'b1, 1'b0);
  endtask

  task automatic enter_shir_from_tlr();
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
  endtask

  // Shift n bits LSB first right after Capture-IR; tdo must stream out the capture pattern
  task automatic shift_bits(input logic [4:0] v, input int n, input logic exit_last);
    logic [4:0] prev_ir;
    prev_ir = m_ir;
    for (int i = 0; i < n; i++) begin
      chk("shir.tdo", 32'(ir_tdo), 32'(i == 0));
      chk("shir.ir_hold", 32'(ir), 32'(prev_ir));
      step(exit_last && (i == n - 1), v[i]);
    end
  endtask

  task automatic load_ir(input logic [4:0] v);
    goto_tlr();
    enter_shir_from_tlr();
    shift_bits(v, 5, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] t0;
    logic [63:0] t1;
    t0 = 64'hCACC_BABA_62CE_3232;
    t1 = 64'hF977_89DD_417F_0155;
    for (int i = 0; i < 16; i++) begin
      nx0[i] = t0[4*i +: 4];
      nx1[i] = t1[4*i +: 4];
    end
    insn_tab[0] = 5'h01; insn_tab[1] = 5'h03; insn_tab[2] = 5'h08; insn_tab[3] = 5'h09;
    insn_tab[4] = 5'h10; insn_tab[5] = 5'h12; insn_tab[6] = 5'h00; insn_tab[7] = 5'h02;

    trst_n = 1'b0;
    tms    = 1'b1;
    tdi    = 1'b0;
    model_reset();
    @(negedge tck);
    reset_pulse();

    // Shift-DR, then five tms=1 edges back to TLR, then to RTI
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("dr.in_shdr", 32'(tap_state), 32'h2);
    goto_tlr();
    chk("dr.back_tlr", 32'(tap_state), 32'hF);
    step(1'b0, 1'b0);
    chk("dr.to_rti", 32'(tap_state), 32'hC);

    load_ir(5'h09);
    chk("ld09.ir",  32'(ir),  32'h09);
    chk("ld09.sel", 32'(sel), 32'h3);
    load_ir(5'h1F);
    chk("ld1f.sel", 32'(sel), 32'h7);
    load_ir(5'h05);
    chk("ld05.sel", 32'(sel), 32'h7);
    load_ir(5'h00);
    chk("ld00.sel", 32'(sel), 32'h6);
    load_ir(5'h12);
    chk("ld12.sel", 32'(sel), 32'h5);

    // From RTI, abort a partial shift of 5'h10 with reset
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    shift_bits(5'h10, 3, 1'b0);
    chk("abort.ir_pre", 32'(ir), 32'h12);
    reset_pulse();
    step(1'b0, 1'b0);
    chk("abort.rti", 32'(tap_state), 32'hC);

    // Random walk with occasional reset
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tap_ir_ctrl.md
TAP_IR_CTRL -- requirements
Module: tap_ir_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 5, instruction register length in bits (minimum 2).
REQ-002 Parameter IR_RESET_VAL, default 5'h01 (ETAP_IDCODE), instruction loaded in Test-Logic-Reset.
REQ-003 Parameter IR_CAPTURE_VAL, default {IR_WIDTH-2 zeros, 2'b01}, pattern loaded in Capture-IR.
REQ-004 Port tck, input, 1, sole clock; all state changes on rising edge.
REQ-005 Port trst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port tms, input, 1, test mode select, sampled on tck rising edge.
REQ-007 Port tdi, input, 1, serial data in, sampled on tck rising edge.
REQ-008 Port tap_state, output, 4, current TAP state code.
REQ-009 Port ir, output, IR_WIDTH, latched (active) instruction.
REQ-010 Port sel, output, 4, registered data-register select decoded from ir.
REQ-011 Port ir_tdo, output, 1, serial IR data out (ir shift stage bit 0).
REQ-012 Ports capture_dr, shift_dr, update_dr, tlr, outputs, 1 each; high while tap_state equals Capture-DR, Shift-DR, Update-DR, Test-Logic-Reset respectively.

Function
REQ-013 The TAP FSM shall implement all 16 IEEE 1149.1 states and tms-driven transitions, with codes TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-014 Five consecutive tck edges with tms=1 shall reach TLR from any state.
REQ-015 In CapIR, the shift stage shall load IR_CAPTURE_VAL on the next edge.
REQ-016 In ShIR, the shift stage shall load {tdi, shift[IR_WIDTH-1:1]} each edge; ir_tdo shall equal shift[0] combinationally.
REQ-017 In UpdIR, ir shall load the shift stage on the next edge, and sel shall update on that same edge.
REQ-018 In TLR, ir shall load IR_RESET_VAL and sel its decode on every edge.
REQ-019 In all other states, ir, sel and the shift stage shall hold.
REQ-020 Decode: 5'h01->0000, 5'h03->0001, 5'h08->0010, 5'h09->0011, 5'h10->0100, 5'h12->0101, 5'h00->0110, 5'h02->0111 (BYPASS); any other value, including all ones, ->0111 (BYPASS).
REQ-021 For IR_WIDTH>5, decode shall compare zero-extended codes; upper non-zero bits select BYPASS.
REQ-022 Outputs capture_dr, shift_dr, update_dr and tlr shall be decoded from registered tap_state only, glitch-free and with no tms combinational path.

Reset
REQ-023 trst_n low shall immediately force tap_state=F, ir=IR_RESET_VAL, sel=decode(IR_RESET_VAL) (0000 by default), shift stage=IR_CAPTURE_VAL, tlr=1, other strobes 0.
REQ-024 Reset asserted mid-shift shall abort the shift; nothing partial shall be latched into ir.
REQ-025 After trst_n release, the first tck edge shall follow REQ-013 from TLR.

Structure
REQ-026 TAP state codes, instruction codes and sel codes shall reside in shared package ejtag_pkg, used by this block and all DR logic.
REQ-027 The decode shall be a separate sub-module ejtag_ir_decode (combinational, parameterised by IR_WIDTH); tap_ir_ctrl shall register its output.

Verification
REQ-028 Assert trst_n=0 -> tap_state=F, ir=5'h01, sel=0000, tlr=1, without any tck edge.
REQ-029 From ShDR, tms=1 for 5 edges -> tap_state=F; from F, tms=0 -> C.
REQ-030 Drive tms 0,1,1,0,0 from TLR, then shift 5'h09 LSB first (tms=1 on last bit), then 1,0 -> after UpdIR, ir=5'h09, sel=0011.
REQ-031 In CapIR->ShIR, ir_tdo over 5 edges -> 1,0,0,0,0; ir holds the previous value throughout.
REQ-032 Shift 5'h1F then 5'h05 -> sel=0111 both times; then shift 5'h00 -> sel=0110.
REQ-033 Pulse trst_n low after 3 ShIR bits of 5'h10 -> ir=5'h01, sel=0000, tap_state=F; ir never shows 5'h10.
